// File: rtl/ysyx_23060124_dmem_responder_if.sv
// LSU <-> data-memory request/response channel, both directions valid/ready.
// master = LSU side, slave = memory responder side.
interface ysyx_23060124_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_size, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_size, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ysyx_23060124_dmem_responder.sv
// Single-outstanding data-memory responder; response appears LATENCY+1 cycles after accept.
// Response is held until resp_ready; no new request is accepted while busy or responding.
module ysyx_23060124_dmem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input logic i_clk,
  input logic i_rst_n,
  ysyx_23060124_dmem_responder_if.slave bus
);
  localparam int          IDXW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  LAT  = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic            accept, enter_resp;
  logic            acc_wen, acc_err;
  logic [31:0]     acc_addr, acc_wdata, off, lane, word, shifted;
  logic [1:0]      acc_size;
  logic [IDXW-1:0] idx;
  logic [4:0]      sh;
  logic [3:0]      be_base, be;

  // With LATENCY==0 the access happens on the accepting edge, so use the live request.
  always_comb begin
    acc_wen   = wen_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_size  = size_q;
    if (state_q == IDLE) begin
      acc_wen   = bus.req_wen;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_size  = bus.req_size;
    end
    off     = acc_addr - ADDR_BASE;
    idx     = off[IDXW+1:2];
    sh      = {acc_addr[1:0], 3'b000};
    acc_err = (acc_size == 2'b11)
           || (acc_size == 2'b01 && acc_addr[0])
           || (acc_size == 2'b10 && acc_addr[1:0] != 2'b00)
           || (off >= SPAN);
    case (acc_size)
      2'b00:   be_base = 4'b0001;
      2'b01:   be_base = 4'b0011;
      default: be_base = 4'b1111;
    endcase
    be      = be_base << acc_addr[1:0];
    lane    = acc_wdata << sh;
    word    = mem_q[idx];
    shifted = word >> sh;
    err_d   = acc_err;
    rdata_d = '0;
    if (!acc_err && !acc_wen) begin
      case (acc_size)
        2'b00:   rdata_d = {24'b0, shifted[7:0]};
        2'b01:   rdata_d = {16'b0, shifted[15:0]};
        default: rdata_d = shifted;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        cnt_d   = LAT;
        state_d = (LAT == 4'd0) ? RESP : BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept     = (state_q == IDLE) && bus.req_valid;
  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wen_q   <= bus.req_wen;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        size_q  <= bus.req_size;
      end
      if (enter_resp) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  // Store commits only on the edge entering RESP; a reset before then drops it.
  always_ff @(posedge i_clk) begin
    if (enter_resp && acc_wen && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= lane[8*b +: 8];
      end
    end
  end
endmodule
